// File: rtl/display_pkg.sv
// Shared message codes and state encoding for the game-status display path.
// The downstream 7-segment driver imports the MSG_* codes from here as well.
package display_pkg;

    localparam logic [3:0] MSG_IDLE  = 4'h0;
    localparam logic [3:0] MSG_READY = 4'h1;
    localparam logic [3:0] MSG_ERR   = 4'h2;
    localparam logic [3:0] MSG_END   = 4'h3;
    localparam logic [3:0] MSG_PLAY  = 4'h4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_PLAY  = 3'd2,
        ST_END   = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    // Digit code shown for a state; blinking states fall back to blank (idle) in the off phase.
    function automatic logic [3:0] state_msg(input state_t st, input logic phase_on);
        logic [3:0] m;
        m = MSG_IDLE;
        case (st)
            ST_READY: m = phase_on ? MSG_READY : MSG_IDLE;
            ST_PLAY:  m = MSG_PLAY;
            ST_END:   m = MSG_END;
            ST_FAULT: m = phase_on ? MSG_ERR : MSG_IDLE;
            default:  m = MSG_IDLE;
        endcase
        return m;
    endfunction

    function automatic logic state_busy(input state_t st);
        return (st == ST_READY) || (st == ST_PLAY) || (st == ST_END);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running modulo-DIV counter; tick is high while the count sits at DIV-1.
// clr restarts the period so the next tick lands DIV cycles later.
module tick_divider #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/display_msg_seq.sv
// Game-status message sequencer: timed FSM driving the four digit codes of the
// 7-segment display driver from start/stop/fault pulses.
module display_msg_seq
    import display_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int BLINK_DIV   = 25_000_000,
    parameter int READY_TICKS = 3,
    parameter int END_TICKS   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       fault,
    output logic [3:0] an0,
    output logic [3:0] an1,
    output logic [3:0] an2,
    output logic [3:0] an3,
    output logic       busy
);

    localparam int MAX_TICKS = (READY_TICKS > END_TICKS) ? READY_TICKS : END_TICKS;
    localparam int SEC_W     = $clog2(MAX_TICKS + 1);

    state_t           state_q, state_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic             phase_q, phase_d;
    logic             entering;
    logic             sec_tick, blink_tick;
    logic             ready_done, end_done;
    logic [3:0]       msg_d;

    // Both dividers restart on state entry so timing is measured from the entry edge.
    tick_divider #(.DIV(TICK_DIV)) u_sec_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (entering),
        .tick  (sec_tick)
    );

    tick_divider #(.DIV(BLINK_DIV)) u_blink_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (entering),
        .tick  (blink_tick)
    );

    // Timeout fires on the tick that would bring the seconds count to its limit.
    assign ready_done = sec_tick && (sec_q == SEC_W'(READY_TICKS - 1));
    assign end_done   = sec_tick && (sec_q == SEC_W'(END_TICKS - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (fault)      state_d = ST_FAULT;
                else if (start) state_d = ST_READY;
            end
            ST_READY: begin
                if (fault)           state_d = ST_FAULT;
                else if (ready_done) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (fault)     state_d = ST_FAULT;
                else if (stop) state_d = ST_END;
            end
            ST_END: begin
                if (fault)         state_d = ST_FAULT;
                else if (end_done) state_d = ST_IDLE;
            end
            ST_FAULT: begin
                if (start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign entering = (state_d != state_q);

    always_comb begin
        sec_d   = sec_q;
        phase_d = phase_q;
        if (entering) begin
            sec_d   = '0;
            phase_d = 1'b1;
        end else begin
            if (sec_tick && (state_q == ST_READY || state_q == ST_END))
                sec_d = sec_q + 1'b1;
            if (blink_tick)
                phase_d = ~phase_q;
        end
    end

    assign msg_d = state_msg(state_d, phase_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sec_q   <= '0;
            phase_q <= 1'b0;
            an0     <= MSG_IDLE;
            an1     <= MSG_IDLE;
            an2     <= MSG_IDLE;
            an3     <= MSG_IDLE;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            phase_q <= phase_d;
            an0     <= msg_d;
            an1     <= msg_d;
            an2     <= msg_d;
            an3     <= msg_d;
            busy    <= state_busy(state_d);
        end
    end

endmodule

// File: tb/tb_display_msg_seq.sv
// Directed bench for display_msg_seq with short divider periods.
module tb_display_msg_seq;

    logic       clk;
    logic       rst_n;
    logic       start, stop, fault;
    logic [3:0] an0, an1, an2, an3;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    display_msg_seq #(
        .TICK_DIV    (10),
        .BLINK_DIV   (4),
        .READY_TICKS (3),
        .END_TICKS   (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .stop  (stop),
        .fault (fault),
        .an0   (an0),
        .an1   (an1),
        .an2   (an2),
        .an3   (an3),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_dig(input string tag, input logic [3:0] exp);
        chk(tag, {an0, an1, an2, an3}, {4{exp}});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Blink pattern: on for edges 0..3 after entry, off for 4..7, and so on.
    function automatic logic [3:0] blink(input int k, input logic [3:0] on_code);
        return ((k / 4) % 2 == 0) ? on_code : 4'h0;
    endfunction

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        fault = 1'b0;
        repeat (3) step();
        chk_dig("reset_digits", 4'h0);
        chk("reset_busy", {15'd0, busy}, 16'd0);
        rst_n = 1'b1;
        step();
        chk_dig("idle_after_reset", 4'h0);

        // start in IDLE -> READY with blink, PLAY exactly 30 cycles after entry
        start = 1'b1;
        step();
        start = 1'b0;
        chk_dig("ready_entry", 4'h1);
        chk("ready_busy", {15'd0, busy}, 16'd1);
        for (int k = 1; k <= 30; k++) begin
            start = (k == 10);
            stop  = (k == 10);
            step();
            start = 1'b0;
            stop  = 1'b0;
            chk_dig($sformatf("ready_k%0d", k), (k == 30) ? 4'h4 : blink(k, 4'h1));
        end
        chk("play_busy", {15'd0, busy}, 16'd1);
        step();
        chk_dig("play_steady", 4'h4);

        // stop in PLAY -> END, back to IDLE after 20 cycles, start ignored meanwhile
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk_dig("end_entry", 4'h3);
        for (int k = 1; k <= 20; k++) begin
            start = (k == 5);
            step();
            start = 1'b0;
            chk_dig($sformatf("end_k%0d", k), (k == 20) ? 4'h0 : 4'h3);
        end
        chk("end_to_idle_busy", {15'd0, busy}, 16'd0);

        // fault during READY -> blinking ERR, stop ignored, held start walks FAULT->IDLE->READY
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk_dig("ready_before_fault", 4'h1);
        fault = 1'b1;
        step();
        fault = 1'b0;
        chk_dig("fault_entry", 4'h2);
        chk("fault_busy", {15'd0, busy}, 16'd0);
        for (int k = 1; k <= 9; k++) begin
            stop = (k == 2);
            step();
            stop = 1'b0;
            chk_dig($sformatf("fault_k%0d", k), blink(k, 4'h2));
        end
        start = 1'b1;
        step();
        chk_dig("fault_ack_idle", 4'h0);
        step();
        start = 1'b0;
        chk_dig("held_start_ready", 4'h1);
        repeat (30) step();
        chk_dig("play_again", 4'h4);

        // simultaneous pulses
        fault = 1'b1;
        stop  = 1'b1;
        step();
        fault = 1'b0;
        stop  = 1'b0;
        chk_dig("fault_over_stop", 4'h2);
        start = 1'b1;
        step();
        chk_dig("fault_ack2", 4'h0);
        step();
        start = 1'b0;
        repeat (30) step();
        chk_dig("play_third", 4'h4);
        stop  = 1'b1;
        start = 1'b1;
        step();
        stop  = 1'b0;
        start = 1'b0;
        chk_dig("stop_over_start", 4'h3);
        repeat (20) step();
        chk_dig("idle_again", 4'h0);

        // async reset mid-PLAY takes effect with no clock edge
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (30) step();
        chk_dig("play_before_reset", 4'h4);
        rst_n = 1'b0;
        #1;
        chk_dig("async_reset_digits", 4'h0);
        chk("async_reset_busy", {15'd0, busy}, 16'd0);
        step();
        rst_n = 1'b1;
        repeat (5) step();
        chk_dig("idle_hold_after_reset", 4'h0);
        chk("idle_hold_busy", {15'd0, busy}, 16'd0);

        // random pulse stream: digits always equal and never above MSG_PLAY
        for (int i = 0; i < 10000; i++) begin
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 7) == 0);
            fault = ($urandom_range(0, 31) == 0);
            step();
            chk("rand_equal", {15'd0, (an0 == an1) && (an1 == an2) && (an2 == an3)}, 16'd1);
            chk("rand_range", {15'd0, an0 <= 4'h4}, 16'd1);
        end
        start = 1'b0;
        stop  = 1'b0;
        fault = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
